// File: rtl/dot_product_pkg.sv
// Shared helpers for the dot-product accumulator: tree depth, pipeline latency and width rules.
package dot_product_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    // Cycles from the in_last sample edge to out_valid: product stage, tree levels, acc, output.
    function automatic int unsigned latency(input int unsigned tree_size);
        return clog2(tree_size) + 2;
    endfunction

    function automatic int unsigned tree_out_width(input int unsigned in_width,
                                                   input int unsigned leaves);
        return in_width + clog2(leaves);
    endfunction

    function automatic int unsigned min_acc_width(input int unsigned data_width,
                                                  input int unsigned tree_size);
        return tree_out_width(2 * data_width, tree_size);
    endfunction

endpackage

// File: rtl/pipe_adder_tree.sv
// Registered, zero-padded, sign-extending adder tree: one register stage per tree level.
module pipe_adder_tree
    import dot_product_pkg::*;
#(
    parameter int unsigned LEAVES   = 16,
    parameter int unsigned IN_WIDTH = 16
) (
    input  logic                                        clk_i,
    input  logic [LEAVES*IN_WIDTH-1:0]                  leaves_i,
    output logic [tree_out_width(IN_WIDTH, LEAVES)-1:0] sum_o
);

    localparam int unsigned Depth    = clog2(LEAVES);
    localparam int unsigned SumWidth = tree_out_width(IN_WIDTH, LEAVES);
    localparam int unsigned Pad      = 1 << Depth;

    logic signed [SumWidth-1:0] leaf [Pad];

    genvar j, n;
    for (j = 0; j < Pad; j++) begin : g_leaf
        if (j < LEAVES) begin : g_real
            assign leaf[j] = SumWidth'($signed(leaves_i[j*IN_WIDTH +: IN_WIDTH]));
        end else begin : g_pad
            assign leaf[j] = '0;
        end
    end

    if (Depth == 0) begin : g_flat
        assign sum_o = leaf[0];
    end else begin : g_tree
        // Heap layout: node n has children 2n+1 and 2n+2; indices from Pad-1 up are leaves.
        logic signed [SumWidth-1:0] node_d [Pad-1];
        logic signed [SumWidth-1:0] node_q [Pad-1];

        for (n = 0; n < Pad - 1; n++) begin : g_node
            logic signed [SumWidth-1:0] lhs;
            logic signed [SumWidth-1:0] rhs;
            if (2 * n + 1 >= Pad - 1) begin : g_from_leaf
                assign lhs = leaf[2*n+1-(Pad-1)];
                assign rhs = leaf[2*n+2-(Pad-1)];
            end else begin : g_from_node
                assign lhs = node_q[2*n+1];
                assign rhs = node_q[2*n+2];
            end
            assign node_d[n] = lhs + rhs;
        end

        always_ff @(posedge clk_i) begin
            node_q <= node_d;
        end

        assign sum_o = node_q[0];
    end

endmodule

// File: rtl/dot_product_acc.sv
// Pipelined signed dot product with frame accumulation.
// Optional output saturation is enabled by defining DOT_PRODUCT_SATURATE_EN.
module dot_product_acc
    import dot_product_pkg::*;
#(
    parameter int unsigned TREE_SIZE  = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH  = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic                             in_last,
    input  logic [DATA_WIDTH*TREE_SIZE-1:0]  in,
    input  logic [DATA_WIDTH*TREE_SIZE-1:0]  kernel,
    output logic                             out_valid,
    output logic [OUT_WIDTH-1:0]             out,
    output logic                             out_sat
);

    localparam int unsigned ProdWidth = 2 * DATA_WIDTH;
    localparam int unsigned SumWidth  = tree_out_width(ProdWidth, TREE_SIZE);
    localparam int unsigned PipeDepth = latency(TREE_SIZE) - 1;

    if (TREE_SIZE < 1) begin : g_tree_size_chk
        $error("TREE_SIZE must be at least 1");
    end
    if (ACC_WIDTH < min_acc_width(DATA_WIDTH, TREE_SIZE)) begin : g_acc_width_chk
        $error("ACC_WIDTH too small for full-precision beat sums");
    end
    if (OUT_WIDTH > ACC_WIDTH) begin : g_out_width_chk
        $error("OUT_WIDTH must not exceed ACC_WIDTH");
    end

    logic [TREE_SIZE*ProdWidth-1:0] prod_d, prod_q;
    logic signed [SumWidth-1:0]     beat_sum;
    logic [ACC_WIDTH-1:0]           beat_ext;
    logic [PipeDepth-1:0]           vld_d, vld_q, lst_d, lst_q;
    logic [ACC_WIDTH-1:0]           acc_d, acc_q;
    logic                           open_d, open_q;
    logic                           done_d, done_q;
    logic [OUT_WIDTH-1:0]           out_d, out_q;
    logic                           out_sat_d, out_sat_q;
    logic                           out_valid_d, out_valid_q;

    always_comb begin
        prod_d = '0;
        for (int i = 0; i < TREE_SIZE; i++) begin
            prod_d[i*ProdWidth +: ProdWidth] =
                ProdWidth'($signed(in[i*DATA_WIDTH +: DATA_WIDTH])) *
                ProdWidth'($signed(kernel[i*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    always_ff @(posedge clock) begin
        prod_q <= prod_d;
    end

    pipe_adder_tree #(
        .LEAVES   (TREE_SIZE),
        .IN_WIDTH (ProdWidth)
    ) u_tree (
        .clk_i    (clock),
        .leaves_i (prod_q),
        .sum_o    (beat_sum)
    );

    assign beat_ext = ACC_WIDTH'(beat_sum);

    // Qualifiers ride alongside the data: stage 0 is the product register.
    always_comb begin
        vld_d    = '0;
        lst_d    = '0;
        vld_d[0] = in_valid;
        lst_d[0] = in_valid & in_last;
        for (int k = 1; k < PipeDepth; k++) begin
            vld_d[k] = vld_q[k-1];
            lst_d[k] = lst_q[k-1];
        end
    end

    always_comb begin
        acc_d  = acc_q;
        open_d = open_q;
        done_d = 1'b0;
        if (vld_q[PipeDepth-1]) begin
            acc_d  = (open_q ? acc_q : '0) + beat_ext;
            open_d = ~lst_q[PipeDepth-1];
            done_d = lst_q[PipeDepth-1];
        end
    end

    always_comb begin
        out_valid_d = done_q;
        out_d       = out_q;
        out_sat_d   = out_sat_q;
        if (done_q) begin
`ifdef DOT_PRODUCT_SATURATE_EN
            // In range iff every bit from the output sign bit upward matches.
            if ((&acc_q[ACC_WIDTH-1:OUT_WIDTH-1]) || !(|acc_q[ACC_WIDTH-1:OUT_WIDTH-1])) begin
                out_d     = acc_q[OUT_WIDTH-1:0];
                out_sat_d = 1'b0;
            end else begin
                out_d     = acc_q[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                               : {1'b0, {(OUT_WIDTH-1){1'b1}}};
                out_sat_d = 1'b1;
            end
`else
            out_d     = OUT_WIDTH'(acc_q);
            out_sat_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_q       <= '0;
            lst_q       <= '0;
            acc_q       <= '0;
            open_q      <= 1'b0;
            done_q      <= 1'b0;
            out_q       <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            lst_q       <= lst_d;
            acc_q       <= acc_d;
            open_q      <= open_d;
            done_q      <= done_d;
            out_q       <= out_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_sat   = out_sat_q;

endmodule
